// File: rtl/mul_32b.sv
// mul_32b: sequential 32x32 unsigned shift-add multiplier, 64-bit product.
// One partial-product step per clock; 32 steps from accept to result.
// Handshake: in_valid starts an operation in IDLE or DONE, busy marks the
// iterations, and out_valid flags that P holds the last result.
// Optional feature macro: MUL_ADDEND_EN -- when defined, the high half of the
// accumulator is preloaded with Z so the result becomes X*Y + Z.
module mul_32b (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  input  logic [31:0] Z,
  input  logic        in_valid,
  output logic [63:0] P,
  output logic        out_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] lo_r, lo_s;
  logic [31:0] hi_r, hi_s;
  logic [31:0] y_r, y_s;
  logic [4:0]  cnt_r, cnt_s;
  logic [63:0] p_r, p_s;
  logic        out_valid_r, out_valid_s;
  logic        busy_r, busy_s;

  logic [32:0] sum_s;
  logic [31:0] hi_step_s;
  logic [31:0] lo_step_s;
  logic [31:0] hi_init_s;

`ifdef MUL_ADDEND_EN
  // Addend build: the accumulator high half starts from Z.
  assign hi_init_s = Z;
`else
  // Plain build: Z is not part of the datapath; fold it into a sink net.
  logic unused_z_s;
  assign hi_init_s  = 32'd0;
  assign unused_z_s = ^Z;
`endif

  // One shift-add step: conditionally add the multiplier, then shift the
  // 33-bit sum and the low half right by one as a single concatenation.
  always_comb begin
    sum_s     = {1'b0, hi_r} + (lo_r[0] ? {1'b0, y_r} : 33'd0);
    hi_step_s = sum_s[32:1];
    lo_step_s = {sum_s[0], lo_r[31:1]};
  end

  // Next-state and next-datapath logic for the IDLE/BUSY/DONE controller.
  always_comb begin
    state_s     = state_r;
    lo_s        = lo_r;
    hi_s        = hi_r;
    y_s         = y_r;
    cnt_s       = cnt_r;
    p_s         = p_r;
    out_valid_s = out_valid_r;
    busy_s      = busy_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (in_valid) begin
          lo_s        = X;
          hi_s        = hi_init_s;
          y_s         = Y;
          cnt_s       = 5'd0;
          busy_s      = 1'b1;
          out_valid_s = 1'b0;
          state_s     = S_BUSY;
        end else begin
          state_s = state_r;
        end
      end
      S_BUSY: begin
        hi_s  = hi_step_s;
        lo_s  = lo_step_s;
        cnt_s = cnt_r + 5'd1;
        if (cnt_r == 5'd31) begin
          p_s         = {hi_step_s, lo_step_s};
          out_valid_s = 1'b1;
          busy_s      = 1'b0;
          state_s     = S_DONE;
        end else begin
          state_s = S_BUSY;
        end
      end
      default: begin
        state_s     = S_IDLE;
        busy_s      = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      lo_r        <= 32'd0;
      hi_r        <= 32'd0;
      y_r         <= 32'd0;
      cnt_r       <= 5'd0;
      p_r         <= 64'd0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      lo_r        <= lo_s;
      hi_r        <= hi_s;
      y_r         <= y_s;
      cnt_r       <= cnt_s;
      p_r         <= p_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
    end
  end

  assign P         = p_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mul_32b.sv
// tb_mul_32b: self-checking bench for mul_32b with a result scoreboard.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge. Honours MUL_ADDEND_EN for the expected-value model.
module tb_mul_32b;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] X, Y, Z;
  logic        in_valid;
  logic [63:0] P;
  logic        out_valid;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  mul_32b dut (
    .clk      (clk),
    .rst      (rst),
    .X        (X),
    .Y        (Y),
    .Z        (Z),
    .in_valid (in_valid),
    .P        (P),
    .out_valid(out_valid),
    .busy     (busy)
  );

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
    logic [63:0] r;
    r = {32'd0, x} * {32'd0, y};
`ifdef MUL_ADDEND_EN
    r = r + {32'd0, z};
`else
    if (z == 32'd0) r = r + 64'd0;
`endif
    return r;
  endfunction

  // Accept one operation, push its expected result, wait (bounded) for out_valid.
  // lat = edges after accept until out_valid (-1 on timeout).
  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                       output int lat, output logic busy_e, output logic ov_e,
                       output logic busy_prev);
    logic last_busy;
    @(negedge clk);
    X = x; Y = y; Z = z; in_valid = 1'b1;
    exp_q.push_back(model(x, y, z));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    X = $urandom; Y = $urandom; Z = $urandom;
    busy_e    = busy;
    ov_e      = out_valid;
    last_busy = busy;
    lat       = -1;
    busy_prev = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        busy_prev = last_busy;
        break;
      end
      last_busy = busy;
    end
  endtask

  task automatic test_reset();
    int lat; logic be, oe, bp; logic [63:0] e;
    repeat (2) @(negedge clk);
    n_checks++; if (P !== 64'd0) begin n_fail++; $display("FAIL reset_p: got %h want 0", P); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ov: got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b1;
    do_op(32'd5, 32'd5, 32'd0, lat, be, oe, bp);
    e = exp_q.pop_front();
    n_checks++; if (P !== e) begin n_fail++; $display("FAIL pre_reset_p: got %h want %h", P, e); end
    // start another op and reset it mid-stream with in_valid held high
    @(negedge clk); X = 32'd7; Y = 32'd7; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0; in_valid = 1'b1;
    #1;
    n_checks++; if (P !== 64'd0) begin n_fail++; $display("FAIL midreset_p: got %h want 0", P); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_ov: got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_held_busy: got %b want 0", busy); end
    in_valid = 1'b0; rst = 1'b1;
    do_op(32'd2, 32'd3, 32'd0, lat, be, oe, bp);
    e = exp_q.pop_front();
    n_checks++; if (P !== e || e !== 64'h6) begin n_fail++; $display("FAIL after_reset_p: got %h want 6", P); end
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL after_reset_lat: got %0d want 32", lat); end
  endtask

  task automatic test_corner();
    int lat; logic be, oe, bp; logic [63:0] e;
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, lat, be, oe, bp);
    e = exp_q.pop_front();
    n_checks++; if (P !== 64'hFFFFFFFE00000001) begin n_fail++; $display("FAIL corner_p: got %h want fffffffe00000001", P); end
    n_checks++; if (P !== e) begin n_fail++; $display("FAIL corner_model: got %h want %h", P, e); end
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL corner_lat: got %0d want 32", lat); end
    n_checks++; if (be !== 1'b1) begin n_fail++; $display("FAIL corner_busy_rise: got %b want 1", be); end
    n_checks++; if (bp !== 1'b1) begin n_fail++; $display("FAIL corner_busy_e31: got %b want 1", bp); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL corner_busy_fall: got %b want 0", busy); end
  endtask

  task automatic test_zero_ignore();
    int lat; logic be, oe, bp; logic [63:0] e;
    do_op(32'd0, 32'h12345678, 32'd0, lat, be, oe, bp);
    e = exp_q.pop_front();
    n_checks++; if (P !== 64'd0 || e !== 64'd0) begin n_fail++; $display("FAIL zero_p: got %h want 0", P); end
    // start 3*5, then pulse in_valid with X=7 at E+10
    @(negedge clk); X = 32'd3; Y = 32'd5; Z = 32'd0; in_valid = 1'b1;
    exp_q.push_back(model(32'd3, 32'd5, 32'd0));
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1; X = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    lat = -1;
    for (int i = 11; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
    e = exp_q.pop_front();
    n_checks++; if (P !== e || e !== 64'hF) begin n_fail++; $display("FAIL ignore_p: got %h want f", P); end
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL ignore_lat: got %0d want 32", lat); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL ignore_norestart: got busy=%b ov=%b want busy=0 ov=1", busy, out_valid);
    end
  endtask

  task automatic test_abort();
    int lat; logic be, oe, bp; logic [63:0] e;
    @(negedge clk); X = 32'hDEADBEEF; Y = 32'h10; Z = 32'd0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2; rst = 1'b0;
    #1;
    n_checks++; if (P !== 64'd0) begin n_fail++; $display("FAIL abort_p: got %h want 0", P); end
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_flags: got ov=%b busy=%b want 0 0", out_valid, busy);
    end
    @(negedge clk); rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_resume: got ov=%b busy=%b want 0 0", out_valid, busy);
    end
    do_op(32'hDEADBEEF, 32'h10, 32'd0, lat, be, oe, bp);
    e = exp_q.pop_front();
    n_checks++; if (P !== 64'h0000000DEADBEEF0 || P !== e) begin
      n_fail++; $display("FAIL abort_restart_p: got %h want 0000000deadbeef0", P);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic be, oe, bp; logic [63:0] e;
    logic [31:0] x, y, z;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_pre_ov: got %b want 1", out_valid); end
    do_op(32'h10000, 32'h10000, 32'd0, lat, be, oe, bp);
    e = exp_q.pop_front();
    n_checks++; if (oe !== 1'b0) begin n_fail++; $display("FAIL b2b_ov_drop: got %b want 0", oe); end
    n_checks++; if (P !== 64'h0000000100000000 || P !== e) begin
      n_fail++; $display("FAIL b2b_p: got %h want 0000000100000000", P);
    end
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL b2b_lat: got %0d want 32", lat); end
    for (int k = 0; k < 1500; k++) begin
      x = $urandom; y = $urandom; z = $urandom;
      if (k % 100 == 0) x = 32'hFFFFFFFF;
      if (k % 150 == 0) y = 32'hFFFFFFFF;
      do_op(x, y, z, lat, be, oe, bp);
      e = exp_q.pop_front();
      n_checks++; if (P !== e) begin
        n_fail++; $display("FAIL rand_p[%0d]: x=%h y=%h z=%h got %h want %h", k, x, y, z, P, e);
      end
      n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL rand_lat[%0d]: got %0d want 32", k, lat); end
    end
  endtask

  task automatic test_addend();
    int lat; logic be, oe, bp; logic [63:0] e;
    logic [63:0] want1, want2;
`ifdef MUL_ADDEND_EN
    want1 = 64'h49; want2 = 64'hFFFFFFFF00000000;
`else
    want1 = 64'h46; want2 = 64'hFFFFFFFE00000001;
`endif
    do_op(32'hA, 32'h7, 32'h3, lat, be, oe, bp);
    e = exp_q.pop_front();
    n_checks++; if (P !== want1 || P !== e) begin n_fail++; $display("FAIL addend_small: got %h want %h", P, want1); end
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, be, oe, bp);
    e = exp_q.pop_front();
    n_checks++; if (P !== want2 || P !== e) begin n_fail++; $display("FAIL addend_max: got %h want %h", P, want2); end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0;
    X = 32'd0; Y = 32'd0; Z = 32'd0;
    test_reset();
    test_corner();
    test_zero_ignore();
    test_abort();
    test_back_to_back();
    test_addend();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
